// File: rtl/sb_initiator.sv
// sb_initiator: serialises alloc / lookup / retire requests onto a scoreboard port that
// takes one operation at a time. Lookup results come back on a valid/ready response
// channel. Occupancy and sticky error flags are reported as status.

`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

module sb_initiator #(
    parameter int unsigned ID_W    = 8,
    parameter int unsigned PID_W   = $clog2(`PROC_COUNT),
    parameter int unsigned TIMEOUT = 2 * `PROC_COUNT + 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    // Alloc channel
    input  logic                          i_al_valid,
    input  logic [ID_W-1:0]               i_al_cmd_id,
    input  logic [PID_W-1:0]              i_al_pid,
    output logic                          o_al_ready,
    // Lookup channel
    input  logic                          i_lk_valid,
    input  logic [ID_W-1:0]               i_lk_cmd_id,
    output logic                          o_lk_ready,
    // Retire channel
    input  logic                          i_rt_valid,
    input  logic [ID_W-1:0]               i_rt_cmd_id,
    output logic                          o_rt_ready,
    // Lookup response
    output logic                          o_rsp_valid,
    output logic                          o_rsp_found,
    output logic [PID_W-1:0]              o_rsp_pid,
    input  logic                          i_rsp_ready,
    // Scoreboard side; entry is {cmd_id, proc_id}
    output logic [ID_W+PID_W-1:0]         o_sb_entry,
    output logic                          o_sb_write,
    output logic                          o_sb_read,
    output logic                          o_sb_flush,
    input  logic                          i_sb_ack,
    input  logic                          i_sb_exists,
    input  logic [PID_W-1:0]              i_sb_id,
    // Status
    output logic [$clog2(`PROC_COUNT):0]  o_occupancy,
    output logic                          o_err_timeout,
    output logic                          o_err_badid
);

    localparam int unsigned OccW = $clog2(`PROC_COUNT) + 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    // The scoreboard always needs one free slot, so allocation stops one short of full.
    localparam logic [OccW-1:0] OccMax = OccW'(`PROC_COUNT - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StGap, StResp} state_e;
    typedef enum logic [1:0] {OpAlloc, OpLookup, OpRetire} op_e;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [ID_W+PID_W-1:0]   entry_q, entry_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [OccW-1:0]         occ_q, occ_d;
    logic                    found_q, found_d;
    logic [PID_W-1:0]        pid_q, pid_d;
    logic                    err_to_q, err_to_d;
    logic                    err_bad_q, err_bad_d;
    logic                    en_q;
    logic                    gnt_al, gnt_lk, gnt_rt;

    // Fixed-priority grant in IDLE: retire > lookup > alloc; alloc gated by occupancy.
    always_comb begin
        gnt_rt = 1'b0;
        gnt_lk = 1'b0;
        gnt_al = 1'b0;
        if (state_q == StIdle && en_q) begin
            if (i_rt_valid) begin
                gnt_rt = 1'b1;
            end else if (i_lk_valid) begin
                gnt_lk = 1'b1;
            end else if (i_al_valid && occ_q < OccMax) begin
                gnt_al = 1'b1;
            end
        end
    end

    // Next-state and output decode for the single-outstanding operation FSM.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        occ_d      = occ_q;
        found_d    = found_q;
        pid_d      = pid_q;
        err_to_d   = err_to_q;
        err_bad_d  = err_bad_q;
        o_sb_write = 1'b0;
        o_sb_read  = 1'b0;
        o_sb_flush = 1'b0;
        o_rsp_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_rt) begin
                    if (i_rt_cmd_id == '0) begin
                        err_bad_d = 1'b1;
                    end else begin
                        op_d    = OpRetire;
                        entry_d = {i_rt_cmd_id, {PID_W{1'b0}}};
                        state_d = StIssue;
                    end
                end else if (gnt_lk) begin
                    if (i_lk_cmd_id == '0) begin
                        // Dropped lookup still owes the consumer a (negative) response.
                        err_bad_d = 1'b1;
                        found_d   = 1'b0;
                        pid_d     = '0;
                        state_d   = StResp;
                    end else begin
                        op_d    = OpLookup;
                        entry_d = {i_lk_cmd_id, {PID_W{1'b0}}};
                        state_d = StIssue;
                    end
                end else if (gnt_al) begin
                    if (i_al_cmd_id == '0) begin
                        err_bad_d = 1'b1;
                    end else begin
                        op_d    = OpAlloc;
                        entry_d = {i_al_cmd_id, i_al_pid};
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                unique case (op_q)
                    OpAlloc:  o_sb_write = 1'b1;
                    OpLookup: o_sb_read  = 1'b1;
                    OpRetire: o_sb_flush = 1'b1;
                    default:  ;
                endcase
                state_d = StWait;
            end
            StWait: begin
                if (i_sb_ack) begin
                    cnt_d   = '0;
                    state_d = StGap;
                    unique case (op_q)
                        OpAlloc: begin
                            if (occ_q < OccMax) occ_d = occ_q + 1'b1;
                        end
                        OpRetire: begin
                            if (i_sb_exists && occ_q != '0) occ_d = occ_q - 1'b1;
                        end
                        OpLookup: begin
                            found_d = i_sb_exists;
                            pid_d   = i_sb_id;
                        end
                        default: ;
                    endcase
                end else if (cnt_q == CntLast) begin
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                    if (op_q == OpLookup) begin
                        found_d = 1'b0;
                        pid_d   = '0;
                        state_d = StResp;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                // Idle cycle while the scoreboard returns to its own idle state.
                state_d = (op_q == OpLookup) ? StResp : StIdle;
            end
            StResp: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, all cleared asynchronously by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            op_q      <= OpAlloc;
            entry_q   <= '0;
            cnt_q     <= '0;
            occ_q     <= '0;
            found_q   <= 1'b0;
            pid_q     <= '0;
            err_to_q  <= 1'b0;
            err_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
            found_q   <= found_d;
            pid_q     <= pid_d;
            err_to_q  <= err_to_d;
            err_bad_q <= err_bad_d;
        end
    end

    // Holds readies low until the first clock edge after reset is released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    assign o_al_ready    = gnt_al;
    assign o_lk_ready    = gnt_lk;
    assign o_rt_ready    = gnt_rt;
    assign o_sb_entry    = entry_q;
    assign o_rsp_found   = found_q;
    assign o_rsp_pid     = pid_q;
    assign o_occupancy   = occ_q;
    assign o_err_timeout = err_to_q;
    assign o_err_badid   = err_bad_q;

endmodule

// File: doc/sb_initiator.md
SB_INITIATOR -- requirements
Module: sb_initiator

Interface
REQ-001 Param ID_W, default 8, cmd_id width; must match entry_t.cmd_id.
REQ-002 Param PID_W, default $clog2(`PROC_COUNT), proc_id width; must match entry_t.proc_id.
REQ-003 Param TIMEOUT, default 2*`PROC_COUNT+4, maximum cycles WAIT tolerates without ack.
REQ-004 One clock; reset is asynchronous and active-high.
- i_clk  in  1  clock.
- i_rst  in  1  async active-high reset.
REQ-005 Alloc channel:
- i_al_valid  in  1  request.
- i_al_cmd_id  in  ID_W  command id.
- i_al_pid  in  PID_W  processor id.
- o_al_ready  out  1  accept.
REQ-006 Lookup channel:
- i_lk_valid  in  1  request.
- i_lk_cmd_id  in  ID_W  command id.
- o_lk_ready  out  1  accept.
REQ-007 Retire channel:
- i_rt_valid  in  1  request.
- i_rt_cmd_id  in  ID_W  command id.
- o_rt_ready  out  1  accept.
REQ-008 Lookup response:
- o_rsp_valid  out  1  response valid.
- o_rsp_found  out  1  key present.
- o_rsp_pid  out  PID_W  owning processor.
- i_rsp_ready  in  1  consumer accept.
REQ-009 Scoreboard side:
- o_sb_entry  out  entry_t  key/value.
- o_sb_write  out  1  add strobe.
- o_sb_read  out  1  lookup strobe.
- o_sb_flush  out  1  remove strobe.
- i_sb_ack  in  1  scoreboard done.
- i_sb_exists  in  1  key found.
- i_sb_id  in  PID_W  found proc id.
REQ-010 Status outputs:
- o_occupancy  out  $clog2(`PROC_COUNT)+1  live entries.
- o_err_timeout  out  1  sticky timeout flag.
- o_err_badid  out  1  sticky flag, cmd_id 0 seen.

Function
REQ-011 The FSM SHALL use states IDLE, ISSUE, WAIT, GAP and RESP.
REQ-012 In IDLE, at most one ready SHALL be high, granted by fixed priority retire > lookup > alloc; a transfer occurs on valid&ready.
REQ-013 o_al_ready SHALL be low when o_occupancy >= `PROC_COUNT-1, because the scoreboard needs one free slot.
REQ-014 A request with cmd_id 0 SHALL be accepted and dropped without any scoreboard access, set o_err_badid, and keep the FSM in IDLE.
  - For a dropped lookup, a RESP with found=0 and pid=0 SHALL still be produced.
REQ-015 On accept, the entry SHALL be registered:
  - Alloc: {cmd_id, pid}.
  - Lookup and retire: {cmd_id, 0}.
  - Transition to ISSUE.
REQ-016 In ISSUE, exactly one strobe (write/read/flush per op) SHALL be high for exactly one cycle, followed by unconditional transition to WAIT.
REQ-017 o_sb_entry SHALL hold constant from ISSUE through the cycle i_sb_ack is sampled.
REQ-018 In WAIT, on i_sb_ack:
  - Alloc: o_occupancy increments.
  - Retire: o_occupancy decrements iff i_sb_exists=1; on exists=0 it holds.
  - Lookup: i_sb_exists and i_sb_id are captured.
  - Next state is GAP.
REQ-019 GAP SHALL last one cycle with all strobes low, covering the scoreboard OUT->IDLE cycle.
  - Exits to RESP for a lookup; otherwise to IDLE.
REQ-020 In RESP, o_rsp_valid SHALL be high with stable found/pid until i_rsp_ready; transfer goes to IDLE; no new request is accepted in RESP.
REQ-021 A WAIT counter SHALL count from 0; if it reaches TIMEOUT without ack:
  - o_err_timeout is set.
  - Occupancy is unchanged.
  - A lookup proceeds to RESP with found=0.
  - Other ops go to IDLE.
  - The counter clears on leaving WAIT.
REQ-022 An i_sb_ack outside WAIT SHALL be ignored.
REQ-023 Occupancy SHALL saturate at 0 on decrement and never exceed `PROC_COUNT-1.
REQ-024 Minimum op latency (accept to next accept) SHALL be: alloc/retire = 3 + scoreboard ack delay; lookup adds one RESP cycle plus consumer stall.

Reset
REQ-025 While i_rst is high, asynchronously, the following SHALL be cleared:
  - State = IDLE.
  - All readies 0.
  - All strobes 0.
  - o_sb_entry = 0.
  - o_rsp_valid = o_rsp_found = o_rsp_pid = 0.
  - o_occupancy = 0.
  - Both error flags = 0.
  - WAIT counter = 0.
REQ-026 A reset asserted mid-operation SHALL abort the op with no response or occupancy change; readies SHALL rise no earlier than the first clock edge after deassertion.

Verification
REQ-027 The bench SHALL cover:
  - Alloc {cmd 5, pid 2}, ack 3 cycles later -> single-cycle o_sb_write; entry {5,2} stable through ack; occupancy 0->1.
  - Lookup cmd 5, scoreboard returns exists=1, id=2 -> o_rsp_valid found=1 pid=2, held while i_rsp_ready=0 for 4 cycles.
  - Retire cmd 9 with exists=0 -> single o_sb_flush pulse; occupancy unchanged; no response.
  - Alloc, lookup and retire valid in the same cycle -> retire served first, then lookup, then alloc; strict one op in flight.
  - Occupancy 3 (`PROC_COUNT=4) -> o_al_ready=0 with lookup and retire still served; retire with exists=1 drops occupancy to 2 and re-enables alloc.
  - Lookup with no ack for TIMEOUT cycles -> o_err_timeout=1, response found=0; then reset mid-WAIT clears all outputs.
